// File: rtl/rx_block_fifo_pkg.sv
// rtl/rx_block_fifo_pkg.sv - shared sizing helpers for the rx block FIFO
package rx_block_fifo_pkg;

  localparam int DATA_W_DEFAULT  = 8;
  localparam int BLOCK_W_DEFAULT = 128;
  localparam int DEPTH_DEFAULT   = 4;

  // Number of received words that make up one block.
  function automatic int words_per_block(input int block_w, input int data_w);
    return block_w / data_w;
  endfunction

  // Width of a counter that runs 0..n-1 (at least one bit).
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Slot index width plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rx_block_fifo_if.sv
// rtl/rx_block_fifo_if.sv - word input / block output bundle, optional level port under RX_BUF_LEVEL_EN
interface rx_block_fifo_if #(
  parameter int DATA_W  = 8,
  parameter int BLOCK_W = 128,
  parameter int DEPTH   = 4
);
  logic [DATA_W-1:0]  din;
  logic               ready;
  logic               flush;
  logic               re;
  logic [BLOCK_W-1:0] dout;
  logic               empty;
  logic               full;
  logic               of;
`ifdef RX_BUF_LEVEL_EN
  logic                   of_clr;
  logic [$clog2(DEPTH):0] level;

  modport master (output din, ready, flush, re, of_clr,
                  input  dout, empty, full, of, level);
  modport slave  (input  din, ready, flush, re, of_clr,
                  output dout, empty, full, of, level);
`else
  modport master (output din, ready, flush, re,
                  input  dout, empty, full, of);
  modport slave  (input  din, ready, flush, re,
                  output dout, empty, full, of);
`endif
endinterface

// File: rtl/rx_block_fifo_assembler.sv
// rtl/rx_block_fifo_assembler.sv - rx_word_assembler: edge-strobed word shifter emitting completed blocks
module rx_word_assembler
  import rx_block_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BLOCK_W   = 128,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  din,
  input  logic               ready,
  input  logic               flush,
  output logic               blk_valid,
  output logic [BLOCK_W-1:0] blk_data
);
  localparam int WPB = words_per_block(BLOCK_W, DATA_W);
  localparam int CW  = count_width(WPB);
  localparam logic [CW-1:0] LAST = CW'(WPB - 1);

  logic               ready_q;
  logic               strobe;
  logic [CW-1:0]      wcnt;
  logic [BLOCK_W-1:0] sreg;
  logic [BLOCK_W-1:0] shifted;

  // ready is a level; only its rising edge delivers a word.
  assign strobe = ready & ~ready_q;

  // Word order decides which end of the block the first word ends up in.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shifted = {sreg[BLOCK_W-DATA_W-1:0], din};
    end else begin : g_lsb
      assign shifted = {din, sreg[BLOCK_W-1:DATA_W]};
    end
  endgenerate

  // The block is handed over combinationally so the FIFO commits at the final strobe edge.
  assign blk_valid = strobe & ~flush & (wcnt == LAST);
  assign blk_data  = shifted;

  // Edge detect, word count and shift register; flush beats a coincident strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      wcnt    <= '0;
      sreg    <= '0;
    end else begin
      ready_q <= ready;
      if (flush) begin
        wcnt <= '0;
        sreg <= '0;
      end else if (strobe) begin
        sreg <= shifted;
        wcnt <= (wcnt == LAST) ? '0 : wcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_block_fifo.sv
// rtl/rx_block_fifo.sv - show-ahead FIFO of assembled blocks; RX_BUF_LEVEL_EN adds level and of_clr
module rx_block_fifo
  import rx_block_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int BLOCK_W   = BLOCK_W_DEFAULT,
  parameter int DEPTH     = DEPTH_DEFAULT,
  parameter int MSB_FIRST = 1
) (
  input logic            clk,
  input logic            reset,
  rx_block_fifo_if.slave bus
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic               blk_valid;
  logic [BLOCK_W-1:0] blk_data;
  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push;
  logic               overflow;
  logic               of;

  rx_word_assembler #(
    .DATA_W    (DATA_W),
    .BLOCK_W   (BLOCK_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_asm (
    .clk       (clk),
    .reset     (reset),
    .din       (bus.din),
    .ready     (bus.ready),
    .flush     (bus.flush),
    .blk_valid (blk_valid),
    .blk_data  (blk_data)
  );

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A pop in the same cycle frees the slot a commit into a full FIFO needs.
  assign pop      = bus.re & ~empty;
  assign push     = blk_valid & (~full | pop);
  assign overflow = blk_valid & full & ~pop;

  assign bus.dout  = mem[rd_ptr[AW-1:0]];
  assign bus.empty = empty;
  assign bus.full  = full;
  assign bus.of    = of;

  // Slot storage; cleared on reset so an empty FIFO shows zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= blk_data;
    end
  end

  // Read and write pointers with wrap bit, modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef RX_BUF_LEVEL_EN
  localparam int LW = $clog2(DEPTH) + 1;
  logic [LW-1:0] level;

  assign bus.level = level;

  // Sticky overflow; a fresh overflow outranks a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      of <= 1'b0;
    end else if (overflow) begin
      of <= 1'b1;
    end else if (bus.of_clr) begin
      of <= 1'b0;
    end
  end

  // Registered occupancy count tracking push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
    end else if (push && !pop) begin
      level <= level + LW'(1);
    end else if (pop && !push) begin
      level <= level - LW'(1);
    end
  end
`else
  // Sticky overflow, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      of <= 1'b0;
    end else if (overflow) begin
      of <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_block_fifo.sv
// tb/tb_rx_block_fifo.sv - randomized and directed bench for rx_block_fifo against a queue model
module tb_rx_block_fifo;
  localparam int DATA_W  = 8;
  localparam int BLOCK_W = 128;
  localparam int DEPTH   = 2;
  localparam int WPB     = BLOCK_W / DATA_W;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  rx_block_fifo_if #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W), .DEPTH(DEPTH)) bus ();

  rx_block_fifo #(
    .DATA_W    (DATA_W),
    .BLOCK_W   (BLOCK_W),
    .DEPTH     (DEPTH),
    .MSB_FIRST (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of whole blocks, list of pending words, sticky flag.
  logic [BLOCK_W-1:0] mq[$];
  logic [DATA_W-1:0]  part[$];
  bit                 m_of;
  bit                 g_clr;

  task automatic check(input string tag, input logic [BLOCK_W-1:0] got,
                       input logic [BLOCK_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [BLOCK_W-1:0] assemble();
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int i = 0; i < WPB; i++) r[BLOCK_W-1-DATA_W*i -: DATA_W] = part[i];
    return r;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".empty"}, BLOCK_W'(bus.empty), BLOCK_W'(mq.size() == 0));
    check({tag, ".full"},  BLOCK_W'(bus.full),  BLOCK_W'(mq.size() == DEPTH));
    check({tag, ".of"},    BLOCK_W'(bus.of),    BLOCK_W'(m_of));
    if (mq.size() != 0) check({tag, ".dout"}, bus.dout, mq[0]);
`ifdef RX_BUF_LEVEL_EN
    check({tag, ".level"}, BLOCK_W'(bus.level), BLOCK_W'(mq.size()));
`endif
  endtask

  // One word: ready high for hold cycles then low one cycle; re/flush only on the strobe cycle.
  task automatic send_word(input logic [DATA_W-1:0] w, input int hold,
                           input bit do_re, input bit do_flush);
    logic [BLOCK_W-1:0] blk;
    bus.din   = w;
    bus.ready = 1'b1;
    bus.re    = do_re;
    bus.flush = do_flush;
`ifdef RX_BUF_LEVEL_EN
    bus.of_clr = g_clr;
`endif
    tick();
    if (do_re && mq.size() > 0) void'(mq.pop_front());
    if (do_flush) begin
      part.delete();
    end else begin
      part.push_back(w);
      if (part.size() == WPB) begin
        blk = assemble();
        part.delete();
        if (mq.size() < DEPTH) mq.push_back(blk);
        else m_of = 1'b1;
      end
    end
    if (g_clr && !(do_flush == 0 && part.size() == 0 && m_of && mq.size() == DEPTH)) m_of = m_of;
    bus.re    = 1'b0;
    bus.flush = 1'b0;
`ifdef RX_BUF_LEVEL_EN
    bus.of_clr = 1'b0;
`endif
    for (int i = 1; i < hold; i++) tick();
    bus.ready = 1'b0;
    tick();
  endtask

  task automatic send_block(input logic [DATA_W-1:0] w);
    for (int i = 0; i < WPB; i++) send_word(w, 1, 1'b0, 1'b0);
  endtask

  task automatic do_pop();
    bus.re = 1'b1;
    tick();
    bus.re = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    part.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mq.delete();
    part.delete();
    m_of = 1'b0;
  endtask

  initial begin
    logic [BLOCK_W-1:0] b1;
    n_checks  = 0;
    n_errors  = 0;
    g_clr     = 1'b0;
    m_of      = 1'b0;
    bus.din   = '0;
    bus.ready = 1'b0;
    bus.flush = 1'b0;
    bus.re    = 1'b0;
`ifdef RX_BUF_LEVEL_EN
    bus.of_clr = 1'b0;
`endif
    do_reset();
    check("reset.dout", bus.dout, '0);
    check_state("reset");

    // Test 1: incrementing words, ready held two cycles each.
    for (int i = 0; i < WPB - 1; i++) send_word(DATA_W'(i), 2, 1'b0, 1'b0);
    check("t1.not_yet", BLOCK_W'(bus.empty), BLOCK_W'(1));
    send_word(DATA_W'(WPB - 1), 2, 1'b0, 1'b0);
    b1 = 128'h000102030405060708090A0B0C0D0E0F;
    check("t1.dout", bus.dout, b1);
    check_state("t1");
    do_pop();
    send_word(8'h77, 5, 1'b0, 1'b0);
    for (int i = 0; i < WPB - 1; i++) send_word(DATA_W'(8'h80 + i), 1, 1'b0, 1'b0);
    check("t1.hold5.head", bus.dout[BLOCK_W-1 -: 16], 128'h7780);
    check_state("t1.hold5");

    // Test 2: three blocks into a two-slot FIFO.
    do_reset();
    send_block(8'hA5);
    send_block(8'h5A);
    check("t2.full", BLOCK_W'(bus.full), BLOCK_W'(1));
    send_block(8'hF1);
    check("t2.of", BLOCK_W'(bus.of), BLOCK_W'(1));
    check("t2.dout", bus.dout, {WPB{8'hA5}});
    check_state("t2");
    do_pop();
    check("t2.pop1", bus.dout, {WPB{8'h5A}});
    do_pop();
    check("t2.empty", BLOCK_W'(bus.empty), BLOCK_W'(1));
    check_state("t2.end");

    // Test 3: partial block flushed.
    do_reset();
    for (int i = 0; i < 8; i++) send_word(DATA_W'($urandom), 1, 1'b0, 1'b0);
    do_flush();
    send_block(8'h3C);
    check("t3.dout", bus.dout, {WPB{8'h3C}});
    do_pop();
    check("t3.one_block", BLOCK_W'(bus.empty), BLOCK_W'(1));
    check_state("t3");

    // Test 4: commit into full FIFO with simultaneous pop.
    do_reset();
    send_block(8'h11);
    send_block(8'h22);
    for (int i = 0; i < WPB - 1; i++) send_word(8'h33, 1, 1'b0, 1'b0);
    send_word(8'h33, 1, 1'b1, 1'b0);
    check("t4.of", BLOCK_W'(bus.of), BLOCK_W'(0));
    check("t4.full", BLOCK_W'(bus.full), BLOCK_W'(1));
    check("t4.head", bus.dout, {WPB{8'h22}});
    do_pop();
    check("t4.kept", bus.dout, {WPB{8'h33}});
    check_state("t4");

    // Test 5: pops while empty, then reset mid-block.
    do_reset();
    for (int i = 0; i < 3; i++) do_pop();
    check_state("t5.empty_pops");
    send_block(8'h4B);
    check("t5.block", bus.dout, {WPB{8'h4B}});
    do_pop();
    for (int i = 0; i < 7; i++) send_word(8'hEE, 1, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < WPB; i++) send_word(DATA_W'(8'h40 + i), 1, 1'b0, 1'b0);
    check("t5.clean", bus.dout, 128'h404142434445464748494A4B4C4D4E4F);
    check_state("t5");

`ifdef RX_BUF_LEVEL_EN
    // Test 6: level steps and overflow clear.
    do_reset();
    check("t6.l0", BLOCK_W'(bus.level), BLOCK_W'(0));
    send_block(8'h01);
    check("t6.l1", BLOCK_W'(bus.level), BLOCK_W'(1));
    send_block(8'h02);
    check("t6.l2", BLOCK_W'(bus.level), BLOCK_W'(2));
    do_pop();
    check("t6.l1b", BLOCK_W'(bus.level), BLOCK_W'(1));
    send_block(8'h03);
    send_block(8'h04);
    check("t6.of_set", BLOCK_W'(bus.of), BLOCK_W'(1));
    bus.of_clr = 1'b1;
    tick();
    bus.of_clr = 1'b0;
    m_of = 1'b0;
    check("t6.of_clr", BLOCK_W'(bus.of), BLOCK_W'(0));
    for (int i = 0; i < WPB - 1; i++) send_word(8'h05, 1, 1'b0, 1'b0);
    g_clr = 1'b1;
    send_word(8'h05, 1, 1'b0, 1'b0);
    g_clr = 1'b0;
    check("t6.of_wins", BLOCK_W'(bus.of), BLOCK_W'(1));
    check_state("t6");
`endif

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act <= 5) begin
        send_word(DATA_W'($urandom), $urandom_range(1, 3),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
      end else if (act <= 7) begin
        do_pop();
      end else if (act == 8) begin
        tick();
      end else if ($urandom_range(0, 2) == 0) begin
        do_flush();
      end else begin
        do_pop();
      end
      check_state("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
